// File: rtl/clock_div_5_pkg.sv
// Shared constants for the clock divider slice: legal divide-ratio bounds.
`timescale 1ns/1ps
package clock_div_5_pkg;
    localparam int DIV_MIN = 2;
    localparam int DIV_MAX = 255;

    function automatic bit div_legal(input int div);
        return (div >= DIV_MIN) && (div <= DIV_MAX);
    endfunction
endpackage

// File: rtl/clock_div_5_mod_counter.sv
// Parameterised modulo-N counter; exposes the registered count and its next value.
`timescale 1ns/1ps
module mod_counter #(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_next
);
    localparam logic [W-1:0] LAST = W'(N - 1);

    always_comb begin
        cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= cnt_next;
    end
endmodule

// File: rtl/clock_div_5.sv
// Divide-by-DIV clock with 50% duty; odd ratios stretch the high phase by half a
// cycle using a falling-edge copy of the rising-edge phase register.
`timescale 1ns/1ps
module clock_div_5
    import clock_div_5_pkg::*;
#(
    parameter int DIV = 5
) (
    input  logic clk,
    input  logic rst,
    output logic clk_out
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2);

    if (!div_legal(DIV)) begin : g_bad_div
        $error("clock_div_5: DIV=%0d outside %0d..%0d", DIV, DIV_MIN, DIV_MAX);
    end

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          pos_q;

    mod_counter #(.N(DIV), .W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt),
        .cnt_next (cnt_next)
    );

    // High while cnt_next is 1..DIV/2, so the first edge out of cnt=0 raises clk_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pos_q <= 1'b0;
        else      pos_q <= (cnt_next <= HALF) && (cnt != CW'(DIV - 1));
    end

    if (DIV % 2 == 1) begin : g_odd
        logic neg_q;

        always_ff @(negedge clk or negedge rst) begin
            if (!rst) neg_q <= 1'b0;
            else      neg_q <= pos_q;
        end

        // pos_q and neg_q move on opposite edges, so the OR cannot glitch.
        assign clk_out = pos_q | neg_q;
    end else begin : g_even
        assign clk_out = pos_q;
    end
endmodule

// File: tb/tb_clock_div_5.sv
// Bench for clock_div_5 at DIV=5,4,3 sharing one clock and reset.
`timescale 1ns/1ps
module tb_clock_div_5;
    logic    clk;
    logic    rst;
    bit      in_rst;
    longint  e0;
    int      vectors;
    int      miscompares;
    logic [2:0] co_all;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference level of a DIV=d output at time t.
    function automatic logic model(input int d, input longint t);
        if (in_rst || t < e0) return 1'b0;
        return ((t - e0) % (d * 10)) < (d * 5);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_div
        localparam int D = 5 - g;
        logic   co;
        logic   exp_q[$];
        longint last_t;
        bit     armed;
        int     nw;

        clock_div_5 #(.DIV(D)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .clk_out (co)
        );

        always @(clk) begin
            logic e;
            exp_q.push_back(model(D, $time + 1));
            #1;
            e = exp_q.pop_front();
            vectors++;
            if (co !== e) begin
                miscompares++;
                $display("FAIL level div=%0d t=%0t got %b want %b", D, $time, co, e);
            end
        end

        always @(co) begin
            if (rst === 1'b1) begin
                if (armed) begin
                    nw++;
                    vectors++;
                    if ($time - last_t != D * 5) begin
                        miscompares++;
                        $display("FAIL width div=%0d t=%0t got %0d ns want %0d ns",
                                 D, $time, $time - last_t, D * 5);
                    end
                end
                armed  = 1'b1;
                last_t = $time;
            end
        end

        always @(negedge rst) armed = 1'b0;
    end

    assign co_all = {g_div[2].co, g_div[1].co, g_div[0].co};

    task automatic release_rst();
        rst    = 1'b1;
        in_rst = 1'b0;
        e0     = (($time - 5) / 10 + 1) * 10 + 5;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (co_all !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_low got %b want 000", co_all);
        end
        #10;
        release_rst();
    endtask

    task automatic test_divide();
        #498;
    endtask

    task automatic test_async_reset();
        #12;
        rst    = 1'b0;
        in_rst = 1'b1;
        #0.5;
        vectors++;
        if (co_all !== 3'b000) begin
            miscompares++;
            $display("FAIL async_clk_out got %b want 000", co_all);
        end
        vectors++;
        if (g_div[0].u_dut.cnt !== '0 || g_div[1].u_dut.cnt !== '0 || g_div[2].u_dut.cnt !== '0) begin
            miscompares++;
            $display("FAIL async_cnt got %0d/%0d/%0d want 0/0/0",
                     g_div[0].u_dut.cnt, g_div[1].u_dut.cnt, g_div[2].u_dut.cnt);
        end
        #9.5;
        release_rst();
        #203;
    endtask

    task automatic test_short_reset();
        #2;
        rst    = 1'b0;
        in_rst = 1'b1;
        #0.5;
        vectors++;
        if (co_all !== 3'b000) begin
            miscompares++;
            $display("FAIL short_rst_clk_out got %b want 000", co_all);
        end
        #5.5;
        release_rst();
        #247;
    endtask

    task automatic test_activity();
        vectors++;
        if (g_div[0].nw < 30 || g_div[1].nw < 30 || g_div[2].nw < 30) begin
            miscompares++;
            $display("FAIL activity widths got %0d/%0d/%0d want >=30 each",
                     g_div[0].nw, g_div[1].nw, g_div[2].nw);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        in_rst      = 1'b1;
        e0          = 0;
        test_reset();
        test_divide();
        test_async_reset();
        test_short_reset();
        test_activity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
